// File: rtl/csr_exe.sv
// rtl/csr_exe.sv - CSR execution unit: one CSR read-modify-write at a time, old value returned to writeback
module csr_exe #(
  parameter int DW     = 64,
  parameter int RNBITS = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              csr_issue_valid,
  output logic              csr_issue_ready,
  input  logic [2:0]        csr_issue_fun,
  input  logic [11:0]       csr_issue_addr,
  input  logic [DW-1:0]     csr_issue_rs1_data,
  input  logic              csr_issue_rs1_isx0,
  input  logic [4:0]        csr_issue_zimm,
  input  logic [RNBITS-1:0] csr_issue_rd,
  output logic [11:0]       csrexe_addr,
  output logic              csrexe_wen,
  output logic [DW-1:0]     csrexe_data_write,
  input  logic [DW-1:0]     csrexe_data_read,
  output logic              csr_wb_valid,
  input  logic              csr_wb_ready,
  output logic [RNBITS-1:0] csr_wb_rd,
  output logic [DW-1:0]     csr_wb_res,
  output logic              csr_wb_illegal
);

  typedef enum logic [1:0] {IDLE, ACCESS, WB} state_t;

  state_t              state, state_nxt;
  logic [1:0]          kind_q;
  logic [11:0]         addr_q;
  logic [DW-1:0]       src_q;
  logic [DW-1:0]       res_q;
  logic [RNBITS-1:0]   rd_q;
  logic                wr_q;
  logic                illegal_q;

  logic [DW-1:0]       issue_src;
  logic                issue_need_wr;
  logic                issue_illegal;
  logic                accept;
  logic [DW-1:0]       new_val;

  // Decode at accept so the ACCESS cycle only has to merge and write.
  assign issue_src     = csr_issue_fun[2] ? {{(DW-5){1'b0}}, csr_issue_zimm} : csr_issue_rs1_data;
  assign issue_need_wr = (csr_issue_fun[1:0] == 2'b01) |
                         ~(csr_issue_fun[2] ? (csr_issue_zimm == 5'd0) : csr_issue_rs1_isx0);
  assign issue_illegal = (csr_issue_fun[1:0] == 2'b00) |
                         (issue_need_wr & (csr_issue_addr[11:10] == 2'b11));
  assign accept        = csr_issue_valid & csr_issue_ready;

  always_comb begin
    new_val = src_q;
    case (kind_q)
      2'b10:   new_val = csrexe_data_read | src_q;
      2'b11:   new_val = csrexe_data_read & ~src_q;
      default: new_val = src_q;
    endcase
  end

  always_comb begin
    state_nxt         = state;
    csr_issue_ready   = 1'b0;
    csrexe_wen        = 1'b0;
    csrexe_data_write = '0;
    csr_wb_valid      = 1'b0;
    case (state)
      IDLE: begin
        csr_issue_ready = ~flush & ~RST;
        if (csr_issue_valid & ~flush & ~RST) state_nxt = ACCESS;
      end
      ACCESS: begin
        csrexe_wen = wr_q & ~illegal_q & ~flush & ~RST;
        if (csrexe_wen) csrexe_data_write = new_val;
        state_nxt = flush ? IDLE : WB;
      end
      WB: begin
        // A flushed result must not be presented even for the flush cycle.
        csr_wb_valid = ~flush & ~RST;
        if (flush | csr_wb_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      kind_q    <= '0;
      addr_q    <= '0;
      src_q     <= '0;
      res_q     <= '0;
      rd_q      <= '0;
      wr_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        kind_q    <= csr_issue_fun[1:0];
        addr_q    <= csr_issue_addr;
        src_q     <= issue_src;
        rd_q      <= csr_issue_rd;
        wr_q      <= issue_need_wr;
        illegal_q <= issue_illegal;
      end
      if (state == ACCESS && !flush) res_q <= illegal_q ? '0 : csrexe_data_read;
    end
  end

  assign csrexe_addr    = addr_q;
  assign csr_wb_rd      = rd_q;
  assign csr_wb_res     = res_q;
  assign csr_wb_illegal = illegal_q;

endmodule

// File: tb/tb_csr_exe.sv
// tb/tb_csr_exe.sv - directed and random checks of csr_exe against a CSR-file reference model
module tb_csr_exe;

  logic        CLK;
  logic        RST;
  logic        flush;
  logic        csr_issue_valid;
  logic        csr_issue_ready;
  logic [2:0]  csr_issue_fun;
  logic [11:0] csr_issue_addr;
  logic [63:0] csr_issue_rs1_data;
  logic        csr_issue_rs1_isx0;
  logic [4:0]  csr_issue_zimm;
  logic [5:0]  csr_issue_rd;
  logic [11:0] csrexe_addr;
  logic        csrexe_wen;
  logic [63:0] csrexe_data_write;
  logic [63:0] csrexe_data_read;
  logic        csr_wb_valid;
  logic        csr_wb_ready;
  logic [5:0]  csr_wb_rd;
  logic [63:0] csr_wb_res;
  logic        csr_wb_illegal;

  int vectors     = 0;
  int miscompares = 0;
  int wen_count   = 0;

  logic [63:0] csr_mem [0:4095];
  logic [63:0] ref_mem [0:4095];

  csr_exe #(.DW(64), .RNBITS(6)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .csr_issue_valid(csr_issue_valid), .csr_issue_ready(csr_issue_ready),
    .csr_issue_fun(csr_issue_fun), .csr_issue_addr(csr_issue_addr),
    .csr_issue_rs1_data(csr_issue_rs1_data), .csr_issue_rs1_isx0(csr_issue_rs1_isx0),
    .csr_issue_zimm(csr_issue_zimm), .csr_issue_rd(csr_issue_rd),
    .csrexe_addr(csrexe_addr), .csrexe_wen(csrexe_wen),
    .csrexe_data_write(csrexe_data_write), .csrexe_data_read(csrexe_data_read),
    .csr_wb_valid(csr_wb_valid), .csr_wb_ready(csr_wb_ready),
    .csr_wb_rd(csr_wb_rd), .csr_wb_res(csr_wb_res), .csr_wb_illegal(csr_wb_illegal)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // CSR file stand-in: combinational read, cleared while RST is high.
  assign csrexe_data_read = csr_mem[csrexe_addr];
  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 4096; i++) csr_mem[i] <= '0;
    end else if (csrexe_wen) begin
      csr_mem[csrexe_addr] <= csrexe_data_write;
    end
    if (csrexe_wen) wen_count <= wen_count + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_ref();
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
  endtask

  task automatic do_op(input logic [2:0] fun, input logic [11:0] addr, input logic [63:0] rs1,
                       input logic isx0, input logic [4:0] zimm, input logic [5:0] rd, input int stall);
    logic [63:0] src, old, nv;
    logic        writes, ill, wen_exp;
    int          wc0;
    src    = fun[2] ? {59'd0, zimm} : rs1;
    writes = (fun[1:0] == 2'b01) || (fun[2] ? (zimm != 0) : !isx0);
    ill    = (fun[1:0] == 2'b00) || (writes && addr >= 12'hC00);
    old    = ref_mem[addr];
    case (fun[1:0])
      2'b01:   nv = src;
      2'b10:   nv = old | src;
      default: nv = old & ~src;
    endcase
    wen_exp = writes && !ill;

    @(negedge CLK);
    csr_issue_valid = 1'b1; csr_issue_fun = fun; csr_issue_addr = addr;
    csr_issue_rs1_data = rs1; csr_issue_rs1_isx0 = isx0; csr_issue_zimm = zimm; csr_issue_rd = rd;
    #1 chk("issue_ready", csr_issue_ready, 1);
    wc0 = wen_count;

    @(negedge CLK);
    csr_issue_valid = 1'b0;
    #1;
    chk("access_addr", csrexe_addr, addr);
    chk("access_wen", csrexe_wen, wen_exp);
    chk("access_wdata", csrexe_data_write, wen_exp ? nv : 64'd0);
    chk("access_wb_valid", csr_wb_valid, 0);
    if (wen_exp) ref_mem[addr] = nv;

    for (int i = 0; i <= stall; i++) begin
      @(negedge CLK);
      csr_wb_ready = (i == stall);
      #1;
      chk("wb_valid", csr_wb_valid, 1);
      chk("wb_rd", csr_wb_rd, rd);
      chk("wb_res", csr_wb_res, ill ? 64'd0 : old);
      chk("wb_illegal", csr_wb_illegal, ill);
      chk("wb_issue_ready", csr_issue_ready, 0);
      chk("wb_wen", csrexe_wen, 0);
    end

    @(negedge CLK);
    csr_wb_ready = 1'b0;
    #1;
    chk("post_wb_valid", csr_wb_valid, 0);
    chk("post_issue_ready", csr_issue_ready, 1);
    chk("wen_pulses", wen_count - wc0, wen_exp ? 1 : 0);
  endtask

  initial begin
    logic [11:0] pool [0:7];
    int          wc0;
    pool[0] = 12'h300; pool[1] = 12'h304; pool[2] = 12'h305; pool[3] = 12'h340;
    pool[4] = 12'hF14; pool[5] = 12'hC00; pool[6] = 12'h7C0; pool[7] = 12'h123;

    RST = 1'b1; flush = 1'b0; csr_issue_valid = 1'b0; csr_issue_fun = '0; csr_issue_addr = '0;
    csr_issue_rs1_data = '0; csr_issue_rs1_isx0 = 1'b0; csr_issue_zimm = '0; csr_issue_rd = '0;
    csr_wb_ready = 1'b0;
    clear_ref();

    repeat (2) @(negedge CLK);
    #1;
    chk("rst_issue_ready", csr_issue_ready, 0);
    chk("rst_wb_valid", csr_wb_valid, 0);
    chk("rst_wb_res", csr_wb_res, 0);
    chk("rst_wb_rd", csr_wb_rd, 0);
    chk("rst_wb_illegal", csr_wb_illegal, 0);
    chk("rst_addr", csrexe_addr, 0);
    chk("rst_wen", csrexe_wen, 0);
    @(negedge CLK);
    RST = 1'b0;
    #1 chk("rst_release_ready", csr_issue_ready, 1);

    do_op(3'b001, 12'h305, 64'h8000_0000, 1'b0, 5'd0, 6'd5, 0);
    do_op(3'b001, 12'h300, 64'h1800, 1'b0, 5'd0, 6'd1, 0);
    do_op(3'b010, 12'h300, 64'h8, 1'b1, 5'd0, 6'd2, 0);
    do_op(3'b010, 12'h300, 64'h8, 1'b0, 5'd0, 6'd3, 0);
    do_op(3'b001, 12'h304, 64'h888, 1'b0, 5'd0, 6'd4, 0);
    do_op(3'b111, 12'h304, 64'h0, 1'b1, 5'd8, 6'd6, 0);
    do_op(3'b110, 12'h304, 64'h0, 1'b1, 5'd0, 6'd7, 0);
    do_op(3'b001, 12'hF14, 64'h55, 1'b0, 5'd0, 6'd8, 0);
    do_op(3'b010, 12'hF11, 64'h0, 1'b1, 5'd0, 6'd9, 0);
    do_op(3'b100, 12'h300, 64'h1, 1'b0, 5'd1, 6'd10, 0);
    do_op(3'b001, 12'h340, 64'hCAFE, 1'b0, 5'd0, 6'd11, 3);

    // Flush while in ACCESS drops the op entirely.
    @(negedge CLK);
    csr_issue_valid = 1'b1; csr_issue_fun = 3'b001; csr_issue_addr = 12'h340; csr_issue_rs1_data = 64'hDEAD;
    csr_issue_rs1_isx0 = 1'b0; csr_issue_rd = 6'd12;
    wc0 = wen_count;
    @(negedge CLK);
    csr_issue_valid = 1'b0; flush = 1'b1;
    #1;
    chk("flush_access_wen", csrexe_wen, 0);
    chk("flush_access_ready", csr_issue_ready, 0);
    @(negedge CLK);
    flush = 1'b0;
    #1;
    chk("flush_wb_valid", csr_wb_valid, 0);
    chk("flush_ready_after", csr_issue_ready, 1);
    chk("flush_wen_pulses", wen_count - wc0, 0);
    do_op(3'b010, 12'h340, 64'h0, 1'b1, 5'd0, 6'd13, 0);

    // Flush in IDLE blocks acceptance.
    @(negedge CLK);
    csr_issue_valid = 1'b1; flush = 1'b1; csr_issue_fun = 3'b001; csr_issue_addr = 12'h305;
    #1 chk("flush_idle_ready", csr_issue_ready, 0);
    @(negedge CLK);
    csr_issue_valid = 1'b0; flush = 1'b0;
    #1;
    chk("flush_idle_wen", csrexe_wen, 0);
    chk("flush_idle_still_idle", csr_issue_ready, 1);

    // Reset while a result waits in WB.
    @(negedge CLK);
    csr_issue_valid = 1'b1; csr_issue_fun = 3'b001; csr_issue_addr = 12'h305;
    csr_issue_rs1_data = 64'h1234; csr_issue_rd = 6'd14;
    @(negedge CLK);
    csr_issue_valid = 1'b0;
    @(negedge CLK);
    #1 chk("rstwb_valid_before", csr_wb_valid, 1);
    RST = 1'b1;
    #1;
    chk("rstwb_ready", csr_issue_ready, 0);
    chk("rstwb_wen", csrexe_wen, 0);
    @(negedge CLK);
    RST = 1'b0;
    clear_ref();
    #1;
    chk("rstwb_valid_after", csr_wb_valid, 0);
    chk("rstwb_res", csr_wb_res, 0);
    chk("rstwb_addr", csrexe_addr, 0);
    chk("rstwb_ready_after", csr_issue_ready, 1);

    for (int n = 0; n < 40; n++) begin
      logic [4:0] z;
      z = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      do_op(3'($urandom_range(0, 7)), pool[$urandom_range(0, 7)], {$urandom, $urandom},
            ($urandom_range(0, 3) == 0), z, 6'($urandom), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
